gf_poly_reduce: RTL and testbench



---
 rtl/gf_poly_reduce.sv | 87 ++++++++
 tb/tb_gf_poly_reduce.sv | 119 +++++++++++
 2 files changed

// File: rtl/gf_poly_reduce.sv
// GF(2^m) polynomial reducer: reduc_in mod polyn_red_in, one registered stage with valid tag.
// Optional malformed-polynomial flag (poly_err) is enabled by defining REDUC_POLY_CHK_EN.
module gf_poly_reduce #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH:0]       polyn_red_in,
    input  logic [2*DATA_WIDTH-1:0]   reduc_in,
`ifdef REDUC_POLY_CHK_EN
    output logic                      poly_err,
`endif
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned W2 = 2 * DATA_WIDTH;

    logic [W2-1:0] work_c;
    logic [W2-1:0] tail_c;
    logic [W-1:0]  red_c;

    logic [W-1:0]  out_q, out_d;
    logic          out_valid_q, out_valid_d;

    // Fold each high term x^i down via x^m == polyn_red_in[m-1:0]; leading coefficient assumed 1.
    always_comb begin
        tail_c = {{W{1'b0}}, polyn_red_in[W-1:0]};
        work_c = reduc_in;
        for (int i = int'(W2) - 1; i >= int'(W); i--) begin
            if (work_c[i]) begin
                work_c[i] = 1'b0;
                work_c    = work_c ^ (tail_c << (i - int'(W)));
            end
        end
        red_c = work_c[W-1:0];
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = red_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef REDUC_POLY_CHK_EN
    logic poly_err_q, poly_err_d;

    always_comb begin
        poly_err_d = poly_err_q;
        if (in_valid) begin
            poly_err_d = ~polyn_red_in[W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poly_err_q <= 1'b0;
        end else begin
            poly_err_q <= poly_err_d;
        end
    end

    assign poly_err = poly_err_q;
`else
    // Leading coefficient only matters to the error flag.
    logic unused_lead_c;
    assign unused_lead_c = polyn_red_in[W];
`endif

endmodule

// File: tb/tb_gf_poly_reduce.sv
// Directed self-checking bench for gf_poly_reduce (DATA_WIDTH = 4), hand-computed expectations.
// Covers poly_err as well when REDUC_POLY_CHK_EN is defined.
module tb_gf_poly_reduce;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W:0]     polyn_red_in;
    logic [2*W-1:0] reduc_in;
    logic           out_valid;
    logic [W-1:0]   out;
`ifdef REDUC_POLY_CHK_EN
    logic           poly_err;
`endif

    int unsigned n_checks;
    int unsigned n_errors;

    gf_poly_reduce #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .polyn_red_in (polyn_red_in),
        .reduc_in     (reduc_in),
`ifdef REDUC_POLY_CHK_EN
        .poly_err     (poly_err),
`endif
        .out_valid    (out_valid),
        .out          (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, then sample just after the capturing edge.
    task automatic apply(input logic v, input logic [W:0] p, input logic [2*W-1:0] r);
        @(negedge clk);
        in_valid     = v;
        polyn_red_in = p;
        reduc_in     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] o, input logic v);
        check({tag, ".out"}, 32'(out), 32'(o));
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        polyn_red_in = '0;
        reduc_in     = '0;
        #12;
        expect_out("reset", 4'd0, 1'b0);
`ifdef REDUC_POLY_CHK_EN
        check("reset.err", 32'(poly_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        apply(1'b1, 5'd19, 8'd90);   expect_out("p19_90", 4'd5, 1'b1);
        apply(1'b1, 5'd19, 8'd255);  expect_out("p19_255", 4'd13, 1'b1);
        apply(1'b1, 5'd19, 8'd16);   expect_out("p19_16", 4'd3, 1'b1);
        apply(1'b1, 5'd19, 8'd15);   expect_out("p19_15_pass", 4'd15, 1'b1);
        apply(1'b1, 5'd19, 8'd0);    expect_out("p19_zero", 4'd0, 1'b1);
        apply(1'b1, 5'd25, 8'd0);    expect_out("p25_zero", 4'd0, 1'b1);
        apply(1'b1, 5'd25, 8'd16);   expect_out("p25_16", 4'd9, 1'b1);
        apply(1'b1, 5'd25, 8'd255);  expect_out("p25_255", 4'd5, 1'b1);

        apply(1'b1, 5'd19, 8'd90);   expect_out("b2b_0", 4'd5, 1'b1);
        apply(1'b1, 5'd19, 8'd16);   expect_out("b2b_1", 4'd3, 1'b1);
        apply(1'b1, 5'd19, 8'd255);  expect_out("b2b_2", 4'd13, 1'b1);
        apply(1'b0, 5'd19, 8'd90);   expect_out("idle_0", 4'd13, 1'b0);
        apply(1'b0, 5'd19, 8'd16);   expect_out("idle_1", 4'd13, 1'b0);

        // Async reset between edges, with a valid sample pending.
        apply(1'b1, 5'd19, 8'd90);   expect_out("pre_rst", 4'd5, 1'b1);
        @(negedge clk);
        reduc_in = 8'd255;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 4'd0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("rst_held", 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 5'd19, 8'd16);   expect_out("post_rst", 4'd3, 1'b1);

`ifdef REDUC_POLY_CHK_EN
        apply(1'b1, 5'd3, 8'd16);    expect_out("bad_poly", 4'd3, 1'b1);
        check("bad_poly.err", 32'(poly_err), 32'd1);
        apply(1'b0, 5'd19, 8'd16);
        check("err_hold", 32'(poly_err), 32'd1);
        apply(1'b1, 5'd19, 8'd16);   expect_out("good_poly", 4'd3, 1'b1);
        check("good_poly.err", 32'(poly_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
